// File: rtl/instr_decode_pipe.sv
// Instruction-decode register slice for the MIPS_Lite core: valid/ready handshake,
// sign-extended immediate, one-bubble load-use interlock, flush and issue/stall counters.
module instr_decode_pipe #(
  parameter int OPCODE_W  = 3,
  parameter int REG_IDX_W = 3,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 16,
  localparam int INSTR_W  = OPCODE_W + 4 + 3 * REG_IDX_W,
  localparam int ADDR_W   = 2 * REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   instruc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPCODE_W-1:0]  ALU_op,
  output logic                 ALU_src_cntrl,
  output logic                 Reg_write,
  output logic                 Mem_write,
  output logic                 Reg_src_cntrl,
  output logic [REG_IDX_W-1:0] Rs,
  output logic [REG_IDX_W-1:0] Rt,
  output logic [REG_IDX_W-1:0] Rd,
  output logic [DATA_W-1:0]    Imm,
  output logic [ADDR_W-1:0]    Addr,
  output logic                 hazard_stall,
  output logic [CNT_W-1:0]     issue_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int CTRL_LSB = 3 * REG_IDX_W;

  function automatic logic signed [DATA_W-1:0] sign_ext(input logic signed [REG_IDX_W-1:0] f);
    return {{(DATA_W - REG_IDX_W){f[REG_IDX_W-1]}}, f};
  endfunction

  // Stage p0: combinational field split of the incoming instruction
  logic [OPCODE_W-1:0]  op_p0;
  logic                 alu_src_p0, reg_write_p0, mem_write_p0, reg_src_p0;
  logic [REG_IDX_W-1:0] rs_p0, rt_p0, rd_p0;
  logic [ADDR_W-1:0]    addr_p0;

  assign op_p0        = instruc[INSTR_W-1 -: OPCODE_W];
  assign alu_src_p0   = instruc[CTRL_LSB + 3];
  assign reg_write_p0 = instruc[CTRL_LSB + 2];
  assign mem_write_p0 = instruc[CTRL_LSB + 1];
  assign reg_src_p0   = instruc[CTRL_LSB];
  assign rs_p0        = instruc[3*REG_IDX_W-1 -: REG_IDX_W];
  assign rt_p0        = instruc[2*REG_IDX_W-1 -: REG_IDX_W];
  assign rd_p0        = instruc[REG_IDX_W-1:0];
  assign addr_p0      = instruc[ADDR_W-1:0];

  // Stage p1: the single output register
  logic                       vld_p1;
  logic [OPCODE_W-1:0]        op_p1;
  logic                       alu_src_p1, reg_write_p1, mem_write_p1, reg_src_p1;
  logic [REG_IDX_W-1:0]       rs_p1, rt_p1, rd_p1;
  logic signed [DATA_W-1:0]   imm_p1;
  logic [ADDR_W-1:0]          addr_p1;
  logic [CNT_W-1:0]           issue_cnt_q, stall_cnt_q;

  logic match, in_xfer, out_xfer;

  // A load sitting in the output register blocks any reader of its destination.
  assign match        = (rs_p0 == rd_p1) | (~alu_src_p0 & (rt_p0 == rd_p1));
  assign hazard_stall = in_valid & vld_p1 & reg_write_p1 & reg_src_p1 & match;
  assign in_ready     = (~vld_p1 | out_ready) & ~hazard_stall & ~flush;
  assign in_xfer      = in_valid & in_ready;
  assign out_xfer     = vld_p1 & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      op_p1        <= '0;
      alu_src_p1   <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_write_p1 <= 1'b0;
      reg_src_p1   <= 1'b0;
      rs_p1        <= '0;
      rt_p1        <= '0;
      rd_p1        <= '0;
      imm_p1       <= '0;
      addr_p1      <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (in_xfer) begin
      vld_p1       <= 1'b1;
      op_p1        <= op_p0;
      alu_src_p1   <= alu_src_p0;
      reg_write_p1 <= reg_write_p0;
      mem_write_p1 <= mem_write_p0;
      reg_src_p1   <= reg_src_p0;
      rs_p1        <= rs_p0;
      rt_p1        <= rt_p0;
      rd_p1        <= rd_p0;
      imm_p1       <= sign_ext(rt_p0);
      addr_p1      <= addr_p0;
    end else if (out_xfer) begin
      vld_p1 <= 1'b0;
    end
  end

  // Counters still see an out-transfer that coincides with a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_xfer)     issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      if (hazard_stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid     = vld_p1;
  assign ALU_op        = op_p1;
  assign ALU_src_cntrl = alu_src_p1;
  assign Reg_write     = reg_write_p1;
  assign Mem_write     = mem_write_p1;
  assign Reg_src_cntrl = reg_src_p1;
  assign Rs            = rs_p1;
  assign Rt            = rt_p1;
  assign Rd            = rd_p1;
  assign Imm           = imm_p1;
  assign Addr          = addr_p1;
  assign issue_cnt     = issue_cnt_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed self-checking bench for instr_decode_pipe.
module tb_instr_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] instruc;
  logic [2:0]  ALU_op, Rs, Rt, Rd;
  logic        ALU_src_cntrl, Reg_write, Mem_write, Reg_src_cntrl, hazard_stall;
  logic [15:0] Imm, issue_cnt, stall_cnt;
  logic [5:0]  Addr;

  int total = 0;
  int bad = 0;
  int exp_issue = 0;
  int exp_stall = 0;

  instr_decode_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruc(instruc), .out_valid(out_valid), .out_ready(out_ready), .ALU_op(ALU_op),
    .ALU_src_cntrl(ALU_src_cntrl), .Reg_write(Reg_write), .Mem_write(Mem_write),
    .Reg_src_cntrl(Reg_src_cntrl), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm), .Addr(Addr),
    .hazard_stall(hazard_stall), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruc = '0;
    #23;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", out_valid); end
    total++; if ({ALU_op, Rs, Rt, Rd, Imm, Addr} !== '0) begin bad++; $display("FAIL reset_fields: got %h want 0", {ALU_op, Rs, Rt, Rd, Imm, Addr}); end
    total++; if (issue_cnt !== 16'd0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", issue_cnt, stall_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_stream();
    instruc = 16'h28D4; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_vld: got %b want 1", out_valid); end
    total++; if ({ALU_op, ALU_src_cntrl, Reg_write, Mem_write, Reg_src_cntrl} !== 7'b001_0100)
      begin bad++; $display("FAIL stream_ctrl: got %b want 0010100", {ALU_op, ALU_src_cntrl, Reg_write, Mem_write, Reg_src_cntrl}); end
    total++; if (Rs !== 3'd3 || Rt !== 3'd2 || Rd !== 3'd4) begin bad++; $display("FAIL stream_regs: got %0d/%0d/%0d want 3/2/4", Rs, Rt, Rd); end
    total++; if (Addr !== 6'h14 || Imm !== 16'h0002) begin bad++; $display("FAIL stream_addr_imm: got %h/%h want 14/0002", Addr, Imm); end
    total++; if (issue_cnt !== 16'(exp_issue)) begin bad++; $display("FAIL stream_cnt0: got %0d want %0d", issue_cnt, exp_issue); end
    for (int i = 0; i < 3; i++) begin
      tick(); exp_issue++;
      total++; if (issue_cnt !== 16'(exp_issue) || out_valid !== 1'b1) begin bad++; $display("FAIL stream_cnt: got %0d/%b want %0d/1", issue_cnt, out_valid, exp_issue); end
    end
    in_valid = 1'b0;
    tick(); exp_issue++;
    total++; if (issue_cnt !== 16'(exp_issue) || out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %0d/%b want %0d/0", issue_cnt, out_valid, exp_issue); end
  endtask

  task automatic test_load_use();
    instruc = 16'h1A43; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_empty_stall: got %b want 0", hazard_stall); end
    tick();
    total++; if (out_valid !== 1'b1 || Reg_src_cntrl !== 1'b1 || Rd !== 3'd3) begin bad++; $display("FAIL lu_load: got %b/%b/%0d want 1/1/3", out_valid, Reg_src_cntrl, Rd); end
    instruc = 16'h28D4;
    #1;
    total++; if (hazard_stall !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL lu_stall: got %b/%b want 1/0", hazard_stall, in_ready); end
    tick(); exp_issue++; exp_stall++;
    total++; if (out_valid !== 1'b0 || hazard_stall !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL lu_bubble: got %b/%b/%b want 0/0/1", out_valid, hazard_stall, in_ready); end
    total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, exp_stall); end
    tick();
    total++; if (out_valid !== 1'b1 || Rs !== 3'd3 || Rd !== 3'd4 || hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_dep: got %b/%0d/%0d/%b want 1/3/4/0", out_valid, Rs, Rd, hazard_stall); end
    in_valid = 1'b0;
    tick(); exp_issue++;
    total++; if (issue_cnt !== 16'(exp_issue) || stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL lu_cnt: got %0d/%0d want %0d/%0d", issue_cnt, stall_cnt, exp_issue, exp_stall); end
  endtask

  task automatic test_no_match();
    instruc = 16'h1A43; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    instruc = 16'h2914;
    #1;
    total++; if (hazard_stall !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL nm_stall: got %b/%b want 0/1", hazard_stall, in_ready); end
    tick(); exp_issue++;
    total++; if (out_valid !== 1'b1 || Rs !== 3'd4 || Rt !== 3'd2 || Reg_src_cntrl !== 1'b0) begin bad++; $display("FAIL nm_b2b: got %b/%0d/%0d/%b want 1/4/2/0", out_valid, Rs, Rt, Reg_src_cntrl); end
    in_valid = 1'b0;
    tick(); exp_issue++;
    total++; if (issue_cnt !== 16'(exp_issue) || stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL nm_cnt: got %0d/%0d want %0d/%0d", issue_cnt, stall_cnt, exp_issue, exp_stall); end
  endtask

  task automatic test_backpressure();
    instruc = 16'h28D4; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    instruc = 16'h2914;
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || Rs !== 3'd3 || Rd !== 3'd4 || Imm !== 16'h0002)
        begin bad++; $display("FAIL bp_hold: got rdy=%b vld=%b rs=%0d rd=%0d imm=%h want 0/1/3/4/0002", in_ready, out_valid, Rs, Rd, Imm); end
      total++; if (issue_cnt !== 16'(exp_issue)) begin bad++; $display("FAIL bp_cnt_hold: got %0d want %0d", issue_cnt, exp_issue); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_rdy: got %b want 1", in_ready); end
    tick(); exp_issue++;
    total++; if (out_valid !== 1'b1 || Rs !== 3'd4 || issue_cnt !== 16'(exp_issue)) begin bad++; $display("FAIL bp_release: got %b/%0d/%0d want 1/4/%0d", out_valid, Rs, issue_cnt, exp_issue); end
    in_valid = 1'b0;
    tick(); exp_issue++;
    total++; if (out_valid !== 1'b0 || issue_cnt !== 16'(exp_issue)) begin bad++; $display("FAIL bp_drain: got %b/%0d want 0/%0d", out_valid, issue_cnt, exp_issue); end
  endtask

  task automatic test_imm();
    logic [15:0] vec [4] = '{16'h0028, 16'h0018, 16'h0038, 16'h0020};
    logic [15:0] exp [4] = '{16'hFFFD, 16'h0003, 16'hFFFF, 16'hFFFC};
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instruc = vec[i];
      tick();
      if (i > 0) exp_issue++;
      total++; if (Imm !== exp[i] || out_valid !== 1'b1) begin bad++; $display("FAIL imm_%0d: got %h/%b want %h/1", i, Imm, out_valid, exp[i]); end
    end
    in_valid = 1'b0;
    tick(); exp_issue++;
    total++; if (issue_cnt !== 16'(exp_issue)) begin bad++; $display("FAIL imm_cnt: got %0d want %0d", issue_cnt, exp_issue); end
  endtask

  task automatic test_flush();
    instruc = 16'h1A43; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    instruc = 16'h2914; flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || issue_cnt !== 16'(exp_issue)) begin bad++; $display("FAIL fl_squash: got %b/%0d want 0/%0d", out_valid, issue_cnt, exp_issue); end
    instruc = 16'h2914; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b1;
    tick(); exp_issue++;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || issue_cnt !== 16'(exp_issue)) begin bad++; $display("FAIL fl_with_xfer: got %b/%0d want 0/%0d", out_valid, issue_cnt, exp_issue); end
  endtask

  task automatic test_reset_mid();
    instruc = 16'h28D4; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || {ALU_op, Reg_write, Rs, Rt, Rd, Imm, Addr} !== '0)
      begin bad++; $display("FAIL mid_reset_fields: got %b/%h want 0/0", out_valid, {ALU_op, Reg_write, Rs, Rt, Rd, Imm, Addr}); end
    total++; if (issue_cnt !== 16'd0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL mid_reset_cnt: got %0d/%0d want 0/0", issue_cnt, stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || Rd !== 3'd4 || issue_cnt !== 16'd0) begin bad++; $display("FAIL mid_first_accept: got %b/%0d/%0d want 1/4/0", out_valid, Rd, issue_cnt); end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_no_match();
    test_backpressure();
    test_imm();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
